regfile_port_arbiter: RTL and testbench



---
 rtl/regfile_port_arbiter_if.sv | 41 ++++
 rtl/regfile_port_arbiter.sv | 97 +++++++++
 tb/tb_regfile_port_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_port_arbiter_if.sv
// Request/response and regfile-side signals of regfile_port_arbiter.
// slave: the arbiter. master: the requesters plus regfile environment.
interface regfile_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // requester A
    logic                  ReqValidA, ReqReadyA, ReqWriteA;
    logic [ADDR_WIDTH-1:0] ReqWrAddrA, ReqRdAddr1A, ReqRdAddr2A;
    logic [DATA_WIDTH-1:0] ReqWrDataA;
    logic                  RspValidA;
    logic [DATA_WIDTH-1:0] RspData1A, RspData2A;
    // requester B
    logic                  ReqValidB, ReqReadyB, ReqWriteB;
    logic [ADDR_WIDTH-1:0] ReqWrAddrB, ReqRdAddr1B, ReqRdAddr2B;
    logic [DATA_WIDTH-1:0] ReqWrDataB;
    logic                  RspValidB;
    logic [DATA_WIDTH-1:0] RspData1B, RspData2B;
    // regfile side
    logic [ADDR_WIDTH-1:0] WriteRegister, ReadRegister1, ReadRegister2;
    logic [DATA_WIDTH-1:0] WriteData, ReadData1, ReadData2;
    logic                  RegWrite;

    modport slave (
        input  ReqValidA, ReqWriteA, ReqWrAddrA, ReqWrDataA, ReqRdAddr1A, ReqRdAddr2A,
        input  ReqValidB, ReqWriteB, ReqWrAddrB, ReqWrDataB, ReqRdAddr1B, ReqRdAddr2B,
        input  ReadData1, ReadData2,
        output ReqReadyA, RspValidA, RspData1A, RspData2A,
        output ReqReadyB, RspValidB, RspData1B, RspData2B,
        output WriteRegister, WriteData, RegWrite, ReadRegister1, ReadRegister2
    );

    modport master (
        output ReqValidA, ReqWriteA, ReqWrAddrA, ReqWrDataA, ReqRdAddr1A, ReqRdAddr2A,
        output ReqValidB, ReqWriteB, ReqWrAddrB, ReqWrDataB, ReqRdAddr1B, ReqRdAddr2B,
        output ReadData1, ReadData2,
        input  ReqReadyA, RspValidA, RspData1A, RspData2A,
        input  ReqReadyB, RspValidB, RspData1B, RspData2B,
        input  WriteRegister, WriteData, RegWrite, ReadRegister1, ReadRegister2
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares one regfile write port and two read ports between requesters A and B.
// One grant per cycle, combinational from ReqValid; read data is registered
// per requester and flagged with a one-cycle RspValid pulse.
// Arbitration is round-robin unless REGFILE_ARB_FIXED_PRIO_EN is defined,
// in which case A always wins and B may starve.
module regfile_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     Clk,
    input  logic                     ResetN,
    regfile_port_arbiter_if.slave    bus
);

    logic                  gnt_a, gnt_b;
    logic                  rsp_vld_a, rsp_vld_b;
    logic [DATA_WIDTH-1:0] rsp_d1_a, rsp_d2_a, rsp_d1_b, rsp_d2_b;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    // Fixed priority: A wins any contention; nothing granted during reset
    always_comb begin
        gnt_a = ResetN & bus.ReqValidA;
        gnt_b = ResetN & bus.ReqValidB & ~bus.ReqValidA;
    end
`else
    logic prio; // 0: A favoured, 1: B favoured

    // Round-robin: the favoured requester wins contention; nothing granted during reset
    always_comb begin
        gnt_a = ResetN & bus.ReqValidA & (~bus.ReqValidB | ~prio);
        gnt_b = ResetN & bus.ReqValidB & (~bus.ReqValidA | prio);
    end

    // Favour the other requester after every grant, hold when idle
    always_ff @(posedge Clk) begin
        if (!ResetN)    prio <= 1'b0;
        else if (gnt_a) prio <= 1'b1;
        else if (gnt_b) prio <= 1'b0;
    end
`endif

    assign bus.ReqReadyA = gnt_a;
    assign bus.ReqReadyB = gnt_b;

    // Steer the granted request onto the regfile ports, all zero when idle
    always_comb begin
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.RegWrite      = 1'b0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        if (gnt_a) begin
            bus.WriteRegister = bus.ReqWrAddrA;
            bus.WriteData     = bus.ReqWrDataA;
            bus.RegWrite      = bus.ReqWriteA;
            bus.ReadRegister1 = bus.ReqRdAddr1A;
            bus.ReadRegister2 = bus.ReqRdAddr2A;
        end else if (gnt_b) begin
            bus.WriteRegister = bus.ReqWrAddrB;
            bus.WriteData     = bus.ReqWrDataB;
            bus.RegWrite      = bus.ReqWriteB;
            bus.ReadRegister1 = bus.ReqRdAddr1B;
            bus.ReadRegister2 = bus.ReqRdAddr2B;
        end
    end

    // Capture read data on accept (pre-write value, same edge as the write)
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            rsp_vld_a <= 1'b0;
            rsp_vld_b <= 1'b0;
            rsp_d1_a  <= '0;
            rsp_d2_a  <= '0;
            rsp_d1_b  <= '0;
            rsp_d2_b  <= '0;
        end else begin
            rsp_vld_a <= gnt_a;
            rsp_vld_b <= gnt_b;
            if (gnt_a) begin
                rsp_d1_a <= bus.ReadData1;
                rsp_d2_a <= bus.ReadData2;
            end
            if (gnt_b) begin
                rsp_d1_b <= bus.ReadData1;
                rsp_d2_b <= bus.ReadData2;
            end
        end
    end

    assign bus.RspValidA = rsp_vld_a;
    assign bus.RspValidB = rsp_vld_b;
    assign bus.RspData1A = rsp_d1_a;
    assign bus.RspData2A = rsp_d2_a;
    assign bus.RspData1B = rsp_d1_b;
    assign bus.RspData2B = rsp_d2_b;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Randomized + directed bench for regfile_port_arbiter with a behavioural
// regfile and a transaction-level reference model of grants and responses.
module tb_regfile_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic Clk = 1'b0;
    logic ResetN;
    always #5 Clk = ~Clk;

    regfile_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    regfile_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .ResetN(ResetN), .bus(bus));

    // behavioural regfile: combinational read, r0 reads zero
    logic [DW-1:0] rf [32] = '{default: '0};
    always_ff @(posedge Clk)
        if (bus.RegWrite && bus.WriteRegister != '0) rf[bus.WriteRegister] <= bus.WriteData;
    assign bus.ReadData1 = (bus.ReadRegister1 == '0) ? '0 : rf[bus.ReadRegister1];
    assign bus.ReadData2 = (bus.ReadRegister2 == '0) ? '0 : rf[bus.ReadRegister2];

    typedef struct {
        bit            v, w;
        logic [AW-1:0] wa, ra1, ra2;
        logic [DW-1:0] wd;
    } req_t;
    req_t rq [2];

    // reference model state
    int            m_prio = 0;
    bit            m_rv [2];
    logic [DW-1:0] m_d1 [2];
    logic [DW-1:0] m_d2 [2];
    logic [DW-1:0] ref_mem [32];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic drive();
        bus.ReqValidA = rq[0].v; bus.ReqWriteA = rq[0].w; bus.ReqWrAddrA = rq[0].wa;
        bus.ReqWrDataA = rq[0].wd; bus.ReqRdAddr1A = rq[0].ra1; bus.ReqRdAddr2A = rq[0].ra2;
        bus.ReqValidB = rq[1].v; bus.ReqWriteB = rq[1].w; bus.ReqWrAddrB = rq[1].wa;
        bus.ReqWrDataB = rq[1].wd; bus.ReqRdAddr1B = rq[1].ra1; bus.ReqRdAddr2B = rq[1].ra2;
    endtask

    task automatic set_req(input int x, input bit v, input bit w, input int wa,
                           input int wd, input int ra1, input int ra2);
        rq[x].v = v; rq[x].w = w; rq[x].wa = AW'(wa); rq[x].wd = DW'(wd);
        rq[x].ra1 = AW'(ra1); rq[x].ra2 = AW'(ra2);
    endtask

    // who should win this cycle, from the arbitration rules
    function automatic int exp_win();
        if (!ResetN) return -1;
        if (rq[0].v && rq[1].v) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            return 0;
`else
            return m_prio;
`endif
        end
        if (rq[0].v) return 0;
        if (rq[1].v) return 1;
        return -1;
    endfunction

    // one clock: check outputs mid-cycle, advance model at the edge; g = observed grant
    task automatic cycle(output int g);
        int w;
        bit e_we;
        logic [AW-1:0] e_wa, e_r1, e_r2;
        logic [DW-1:0] e_wd;
        drive();
        @(negedge Clk);
        w = exp_win();
        g = bus.ReqReadyA ? 0 : (bus.ReqReadyB ? 1 : -1);
        e_we = 0; e_wa = '0; e_r1 = '0; e_r2 = '0; e_wd = '0;
        if (w >= 0) begin
            e_we = rq[w].w; e_wa = rq[w].wa; e_wd = rq[w].wd;
            e_r1 = rq[w].ra1; e_r2 = rq[w].ra2;
        end
        chk("readyA", bus.ReqReadyA, w == 0);
        chk("readyB", bus.ReqReadyB, w == 1);
        chk("regwrite", bus.RegWrite, e_we);
        chk("wraddr", bus.WriteRegister, e_wa);
        chk("wrdata", bus.WriteData, e_wd);
        chk("rdreg1", bus.ReadRegister1, e_r1);
        chk("rdreg2", bus.ReadRegister2, e_r2);
        chk("rspvA", bus.RspValidA, m_rv[0]);
        chk("rspvB", bus.RspValidB, m_rv[1]);
        chk("rspv_both", bus.RspValidA & bus.RspValidB, 0);
        chk("rspA1", bus.RspData1A, m_d1[0]);
        chk("rspA2", bus.RspData2A, m_d2[0]);
        chk("rspB1", bus.RspData1B, m_d1[1]);
        chk("rspB2", bus.RspData2B, m_d2[1]);
        @(posedge Clk);
        if (w < 0 && !ResetN) begin
            m_prio = 0;
            for (int x = 0; x < 2; x++) begin m_rv[x] = 0; m_d1[x] = '0; m_d2[x] = '0; end
        end else begin
            for (int x = 0; x < 2; x++) m_rv[x] = (w == x);
            if (w >= 0) begin
                m_d1[w] = ref_mem[rq[w].ra1];
                m_d2[w] = ref_mem[rq[w].ra2];
                if (rq[w].w && rq[w].wa != '0) ref_mem[rq[w].wa] = rq[w].wd;
                m_prio = (w == 0) ? 1 : 0;
            end
        end
        #1;
    endtask

    task automatic chk_mem();
        for (int i = 0; i < 32; i++) chk($sformatf("mem_r%0d", i), rf[i], ref_mem[i]);
    endtask

    initial begin
        int g;
        int gs [4];
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        for (int x = 0; x < 2; x++) begin m_rv[x] = 0; m_d1[x] = '0; m_d2[x] = '0; end

        // reset with both requesters valid and writing
        ResetN = 1'b0;
        set_req(0, 1, 1, 1, 'h11, 1, 1);
        set_req(1, 1, 1, 4, 'h44, 4, 4);
        drive();
        @(posedge Clk); #1;
        cycle(g); chk("rst_grant", g, -1);
        cycle(g);
        chk("rst_r1", rf[1], 0);
        chk("rst_r4", rf[4], 0);
        chk_mem();
        ResetN = 1'b1;

        // single requester: write 42 to r2, read r2 same request -> old 0
        set_req(1, 0, 0, 0, 0, 0, 0);
        set_req(0, 1, 1, 2, 42, 2, 2);
        cycle(g);
        chk("t2_rspv", bus.RspValidA, 1);
        chk("t2_old1", bus.RspData1A, 0);
        chk("t2_old2", bus.RspData2A, 0);
        set_req(0, 1, 0, 0, 0, 2, 2);
        cycle(g);
        chk("t2_new1", bus.RspData1A, 42);
        chk("t2_new2", bus.RspData2A, 42);
        set_req(0, 0, 0, 0, 0, 0, 0);
        cycle(g);
        chk("t2_pulse", bus.RspValidA, 0);
        chk("t2_hold", bus.RspData1A, 42);

        // B-only read so A is favoured, then 4 cycles of contention
        set_req(1, 1, 0, 0, 0, 0, 0);
        cycle(g);
        set_req(0, 1, 1, 3, 15, 0, 0);
        set_req(1, 1, 0, 0, 0, 3, 3);
        for (int i = 0; i < 4; i++) begin
            cycle(gs[i]);
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            if (i == 1) chk("t3_b_first", bus.RspData1B, 15);
`endif
        end
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) chk($sformatf("t3_fixed_g%0d", i), gs[i], 0);
`else
        for (int i = 0; i < 4; i++) chk($sformatf("t3_rr_g%0d", i), gs[i], i % 2);
`endif

        // B's write held while A wins; commits only when B is granted
        set_req(0, 1, 1, 6, 'h66, 0, 0);
        set_req(1, 1, 1, 5, 'h55, 5, 5);
        cycle(g);
        chk("t4_a_wins", g, 0);
        chk("t4_b_nocommit", rf[5], 0);
        set_req(0, 0, 0, 0, 0, 0, 0);
        cycle(g);
        chk("t4_b_granted", g, 1);
        chk("t4_b_commit", rf[5], 'h55);

        // reset mid-stream: A grant makes B favoured, then reset while both write
        set_req(0, 1, 0, 0, 0, 1, 1);
        set_req(1, 0, 0, 0, 0, 0, 0);
        cycle(g);
        set_req(0, 1, 1, 7, 'h77, 0, 0);
        set_req(1, 1, 1, 8, 'h88, 0, 0);
        ResetN = 1'b0;
        cycle(g);
        chk("t5_r7", rf[7], 0);
        chk("t5_r8", rf[8], 0);
        ResetN = 1'b1;
        cycle(g);
        chk("t5_a_first", g, 0);

        // A and B valid 3 cycles, then A drops
        set_req(0, 1, 0, 0, 0, 1, 2);
        set_req(1, 1, 0, 0, 0, 3, 4);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) set_req(0, 0, 0, 0, 0, 0, 0);
            cycle(gs[i]);
        end
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        chk("t6_g0", gs[0], 0);
        chk("t6_g1", gs[1], 0);
        chk("t6_g2", gs[2], 0);
        chk("t6_g3", gs[3], 1);
`endif

        // random traffic; unaccepted requests keep their payload
        set_req(0, 0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0, 0);
        g = -1;
        for (int n = 0; n < 400; n++) begin
            bit was_rst;
            was_rst = !ResetN;
            for (int x = 0; x < 2; x++) begin
                if (!(rq[x].v && g != x && !was_rst))
                    set_req(x, ($urandom % 4) != 0, $urandom % 2, $urandom % 8,
                            int'($urandom), $urandom % 8, $urandom % 8);
            end
            ResetN = ($urandom % 40) != 0;
            cycle(g);
        end
        ResetN = 1'b1;
        chk_mem();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
